// File: rtl/impl_sweep_checker.sv
// Exhaustive checker for a 2-input combinational DUT: walks {x,y} through 00..11, holds each
// vector SETTLE cycles, samples dut_s once per vector against a truth table and collects the
// mismatch count and per-vector failure mask.
module impl_sweep_checker #(
  parameter int unsigned SETTLE    = 1,
  parameter logic [3:0]  EXPECT_TT = 4'b1011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dut_s,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {StIdle, StWait, StSample, StDone} state_e;

  localparam logic [3:0] CntLoad = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] xy_q, xy_d;
  logic [2:0] err_q, err_d;
  logic [3:0] mask_q, mask_d;

  // Next-state logic; every register holds unless a state explicitly updates it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    xy_d    = xy_q;
    err_d   = err_q;
    mask_d  = mask_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          err_d   = 3'd0;
          mask_d  = 4'd0;
          idx_d   = 2'd0;
          xy_d    = 2'b00;
          cnt_d   = CntLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSample: begin
        // At most four samples per sweep, so err_q cannot wrap.
        if (dut_s != EXPECT_TT[idx_q]) begin
          mask_d[idx_q] = 1'b1;
          err_d         = err_q + 3'd1;
        end
        if (idx_q == 2'd3) begin
          xy_d    = 2'b00;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 2'd1;
          xy_d    = idx_q + 2'd1;
          cnt_d   = CntLoad;
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      xy_q    <= 2'b00;
      err_q   <= 3'd0;
      mask_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      xy_q    <= xy_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    x         = xy_q[1];
    y         = xy_q[0];
    busy      = (state_q == StWait) || (state_q == StSample);
    done      = (state_q == StDone);
    pass      = (state_q == StDone) && (err_q == 3'd0);
    err_count = err_q;
    fail_mask = mask_q;
  end

endmodule

// File: tb/tb_impl_sweep_checker.sv
// Directed bench for impl_sweep_checker: SETTLE=1 instance for function, faults, restart,
// abort and back-to-back sweeps; SETTLE=3 instance for the stretched vector timing.
module tb_impl_sweep_checker;

  logic       clk = 1'b0;
  logic       reset, start, start3;
  logic       dut_s, dut_s3;
  logic       x, y, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;
  logic       x3, y3, busy3, done3, pass3;
  logic [2:0] err_count3;
  logic [3:0] fail_mask3;
  logic [2:0] mode;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] xy_log[64];
  logic       busy_log[64];
  int         done_edge;

  always #5 clk = ~clk;

  impl_sweep_checker #(.SETTLE(1), .EXPECT_TT(4'b1011)) u_dut (
    .clk(clk), .reset(reset), .start(start), .dut_s(dut_s),
    .x(x), .y(y), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_mask(fail_mask)
  );

  impl_sweep_checker #(.SETTLE(3), .EXPECT_TT(4'b1011)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .dut_s(dut_s3),
    .x(x3), .y(y3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err_count3), .fail_mask(fail_mask3)
  );

  // Models of the device under check.
  always_comb begin
    case (mode)
      3'd0:    dut_s = ~x | y;
      3'd1:    dut_s = 1'b1;
      3'd2:    dut_s = x & y;
      3'd3:    dut_s = 1'b0;
      default: dut_s = x & ~y;
    endcase
  end
  assign dut_s3 = ~x3 | y3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches a sweep on u_dut (start seen at edge 0) and logs outputs after every edge.
  task automatic sweep1(input int restart_at);
    done_edge = -1;
    for (int e = 0; e < 40; e++) begin
      start = (e == 0) || (e == restart_at);
      tick();
      start = 1'b0;
      xy_log[e]   = {x, y};
      busy_log[e] = busy;
      if (done) begin
        done_edge = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; start3 = 1'b1;
    tick();
    n_checks++;
    if ({x, y, busy, done, pass, err_count, fail_mask} !== 12'd0)
      $display("FAIL reset_outputs: got %b, want 0", {x, y, busy, done, pass, err_count, fail_mask});
    else n_pass++;
    n_checks++;
    if ({x3, y3, busy3, done3, pass3, err_count3, fail_mask3} !== 12'd0)
      $display("FAIL reset_outputs3: got %b, want 0",
               {x3, y3, busy3, done3, pass3, err_count3, fail_mask3});
    else n_pass++;
    reset = 1'b0; start = 1'b0; start3 = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_hold: busy=%b done=%b, want 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_correct();
    logic [15:0] seq;
    logic [7:0]  bseq;
    mode = 3'd0;
    sweep1(-1);
    n_checks++;
    if (done_edge !== 8) $display("FAIL done_latency: got %0d, want 8", done_edge);
    else n_pass++;
    for (int e = 0; e < 8; e++) begin
      seq  = {seq[13:0], xy_log[e]};
      bseq = {bseq[6:0], busy_log[e]};
    end
    n_checks++;
    if (seq !== 16'b00_00_01_01_10_10_11_11) $display("FAIL xy_sequence: got %b, want 0000010110101111", seq);
    else n_pass++;
    n_checks++;
    if (bseq !== 8'hFF || busy !== 1'b0 || {x, y} !== 2'b00)
      $display("FAIL busy_xy_done: busy_seq=%h busy=%b xy=%b, want ff 0 00", bseq, busy, {x, y});
    else n_pass++;
    n_checks++;
    if ({pass, err_count, fail_mask} !== 8'b1_000_0000)
      $display("FAIL correct_result: pass/err/mask=%b/%0d/%b, want 1/0/0000", pass, err_count, fail_mask);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if ({done, pass, err_count, fail_mask} !== 9'b1_1_000_0000)
      $display("FAIL done_hold: done/pass/err/mask=%b/%b/%0d/%b, want 1/1/0/0000",
               done, pass, err_count, fail_mask);
    else n_pass++;
  endtask

  task automatic test_faults();
    logic [2:0] modes[4]    = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [2:0] exp_err[4]  = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [3:0] exp_mask[4] = '{4'b0100, 4'b0011, 4'b1011, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      mode = modes[i];
      sweep1(-1);
      n_checks++;
      if (done_edge !== 8 || err_count !== exp_err[i] || fail_mask !== exp_mask[i] || pass !== 1'b0)
        $display("FAIL fault_mode%0d: edge=%0d err=%0d mask=%b pass=%b, want 8 %0d %b 0",
                 modes[i], done_edge, err_count, fail_mask, pass, exp_err[i], exp_mask[i]);
      else n_pass++;
    end
  endtask

  task automatic test_restart_ignored();
    mode = 3'd0;
    sweep1(3);
    n_checks++;
    if (done_edge !== 8 || pass !== 1'b1 || err_count !== 3'd0)
      $display("FAIL restart_ignored: edge=%0d pass=%b err=%0d, want 8 1 0", done_edge, pass, err_count);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    mode = 3'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_checks++;
    if ({x, y} !== 2'b10 || err_count !== 3'd2)
      $display("FAIL abort_setup: xy=%b err=%0d, want 10 2", {x, y}, err_count);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({x, y, busy, done, pass, err_count, fail_mask} !== 12'd0)
      $display("FAIL abort_outputs: got %b, want 0", {x, y, busy, done, pass, err_count, fail_mask});
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_idle: busy=%b done=%b, want 0 0", busy, done);
    else n_pass++;
    mode = 3'd0;
    sweep1(-1);
    n_checks++;
    if (done_edge !== 8 || pass !== 1'b1)
      $display("FAIL after_abort: edge=%0d pass=%b, want 8 1", done_edge, pass);
    else n_pass++;
  endtask

  task automatic test_settle3();
    int d3 = -1;
    logic seq_ok = 1'b1;
    for (int e = 0; e < 40; e++) begin
      start3 = (e == 0);
      tick();
      start3 = 1'b0;
      if (done3) begin
        d3 = e;
        break;
      end
      if (e < 16 && {x3, y3} !== 2'(e / 4)) seq_ok = 1'b0;
    end
    n_checks++;
    if (d3 !== 16 || seq_ok !== 1'b1 || pass3 !== 1'b1)
      $display("FAIL settle3: edge=%0d seq_ok=%b pass=%b, want 16 1 1", d3, seq_ok, pass3);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mode  = 3'd0;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_done = (i == 8) || (i == 17);
      n_checks++;
      if (done !== exp_done || (exp_done && pass !== 1'b1))
        $display("FAIL b2b_edge%0d: done=%b pass=%b, want done=%b pass=1", i, done, pass, exp_done);
      else n_pass++;
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start3 = 1'b0; mode = 3'd0;
    test_reset();
    test_correct();
    test_faults();
    test_restart_ignored();
    test_reset_abort();
    test_settle3();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/impl_sweep_checker.md
IMPL_SWEEP_CHECKER -- requirements
Module: impl_sweep_checker

Interface
REQ-001 The block SHALL have a parameter SETTLE, default 1, giving the cycles each input vector is held before the DUT output is sampled (legal range 1..15).
REQ-002 The block SHALL have a parameter EXPECT_TT, default 4'b1011, giving the expected DUT output per vector index {x,y}; the default is the implication ~x|y.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request a sweep; sampled only in IDLE or DONE.
REQ-006 Port dut_s, input, 1 bit: output of the 2-input DUT under check.
REQ-007 Port x, output, 1 bit: DUT input a, driven from a register.
REQ-008 Port y, output, 1 bit: DUT input b, driven from a register.
REQ-009 Port busy, output, 1 bit: high in WAIT and SAMPLE.
REQ-010 Port done, output, 1 bit: high in DONE.
REQ-011 Port pass, output, 1 bit: high in DONE when err_count==0; low in all other states.
REQ-012 Port err_count, output, 3 bits: number of mismatching vectors, 0..4.
REQ-013 Port fail_mask, output, 4 bits: bit i set when vector i mismatched.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, WAIT, SAMPLE and DONE.
REQ-015 In IDLE or DONE with start=1, the block SHALL clear err_count and fail_mask, set idx=0 and {x,y}=2'b00, load cnt=SETTLE-1, and go to WAIT.
REQ-016 In IDLE with start=0, the block SHALL stay in IDLE; in DONE with start=0, it SHALL stay in DONE and hold all results.
REQ-017 In WAIT, the block SHALL go to SAMPLE when cnt==0; otherwise it SHALL decrement cnt and stay in WAIT.
REQ-018 In SAMPLE with dut_s != EXPECT_TT[idx], the block SHALL set fail_mask[idx] and increment err_count by 1.
REQ-019 In SAMPLE with idx==3, the block SHALL go to DONE and drive {x,y}=2'b00.
REQ-020 In SAMPLE with idx<3, the block SHALL increment idx, drive {x,y}=idx+1, reload cnt=SETTLE-1, and go to WAIT.
REQ-021 Each vector SHALL occupy exactly SETTLE+1 cycles.
REQ-022 done SHALL first be high 4*(SETTLE+1) rising edges after the edge that sampled start (8 edges for SETTLE=1).
REQ-023 start asserted while in WAIT or SAMPLE SHALL be ignored, with no restart and no effect on results.
REQ-024 A start held high in DONE SHALL launch a new sweep immediately, so done stays high for exactly one cycle per sweep.
REQ-025 err_count SHALL never exceed 4; 3 bits SHALL suffice, with no wrap.
REQ-026 x and y SHALL change only on clock edges, never combinationally from start or dut_s.
REQ-027 dut_s SHALL be ignored in every state except SAMPLE.

Reset
REQ-028 With reset=1 at a rising edge, the block SHALL go to IDLE with x=0, y=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, idx=0 and cnt=0.
REQ-029 reset SHALL take priority over start in the same cycle.
REQ-030 A reset during a sweep SHALL abort it, discard partial results, and leave the block in IDLE until the next start.

Verification
REQ-031 SETTLE=1, dut_s=~x|y, start pulsed 1 cycle -> done=1 on the 8th edge after start; pass=1, err_count=0, fail_mask=0000; observed {x,y} sequence 00,00,01,01,10,10,11,11.
REQ-032 dut_s stuck at 1 -> err_count=1, fail_mask=0100, pass=0.
REQ-033 dut_s=x&y -> err_count=2, fail_mask=0011; dut_s stuck at 0 -> err_count=3, fail_mask=1011.
REQ-034 SETTLE=3 with a correct DUT -> each {x,y} held 4 cycles, done on the 16th edge, pass=1.
REQ-035 start re-pulsed during WAIT -> completion timing is unchanged; reset asserted at vector 2 -> all outputs 0 next cycle, state IDLE, and a following start completes normally.
REQ-036 start held high for 20 cycles with a correct DUT -> back-to-back sweeps, done high 1 cycle every 9 cycles, pass=1 each time.
